uart_stim_tx: RTL and testbench

Synthesizable UART transmit stimulus generator for the Guineveer simulation environment. Test stimulus enqueues bytes through a valid/ready push port. The block serialises them as 8-bit LSB-first frames on `tx_o`, which drives the SoC `uart_rx_i` input. Bit period, parity and stop bits are programmable, so the frames match the SoC UART configuration and firmware receive paths can be exercised.

---
 rtl/uart_stim_pkg.sv | 19 +
 rtl/uart_stim_fifo.sv | 66 ++++++
 rtl/uart_stim_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_stim_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stim_pkg.sv
// Shared types and constants for the UART transmit stimulus generator.
package uart_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_stim_state_e;

    localparam int DATA_BITS   = 8;
    localparam int MIN_BIT_CYC = 2;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// Synchronous byte FIFO with flush; read data is the head entry, combinationally.
module uart_stim_fifo
    import uart_stim_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       core_clk,
    input  logic                       rst_l,
    input  logic                       push,
    input  logic [DATA_BITS-1:0]       push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [DATA_BITS-1:0]       pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic                 push_en_s;
    logic                 pop_en_s;

    // Flush blocks both push and pop so a flushing cycle always ends empty.
    always_comb begin
        full      = (count_r == (AW+1)'(DEPTH));
        empty     = (count_r == (AW+1)'(0));
        push_en_s = push && !full && !flush;
        pop_en_s  = pop && !empty && !flush;
        level     = count_r;
        pop_data  = mem_r[rd_ptr_r];
    end

    // Storage array write port.
    always_ff @(posedge core_clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge core_clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_en_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_stim_tx.sv
// UART transmit stimulus generator: queued bytes leave as 8N1/8P1/8N2-style
// LSB-first frames with a programmable bit period latched per frame.
module uart_stim_tx
    import uart_stim_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int STOP_BITS = 1,
    parameter int CYC_W     = 16
) (
    input  logic                   core_clk,
    input  logic                   rst_l,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [7:0]             push_data,
    input  logic                   flush,
    input  logic [CYC_W-1:0]       bit_cycles,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    output logic                   tx_o,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   byte_done
);

    localparam logic [CYC_W-1:0] MIN_PER  = CYC_W'(MIN_BIT_CYC);
    localparam logic [CYC_W-1:0] ONE_CYC  = CYC_W'(1);
    localparam logic [CYC_W-1:0] ZERO_CYC = CYC_W'(0);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    uart_stim_state_e     state_r;
    logic [DATA_BITS-1:0] data_r;
    logic [CYC_W-1:0]     per_r;
    logic [CYC_W-1:0]     cnt_r;
    logic [2:0]           bit_idx_r;
    logic                 stop_idx_r;
    logic                 par_en_r;
    logic                 par_odd_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 byte_done_r;

    logic [DATA_BITS-1:0] fifo_data_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 last_stop_s;
    logic [CYC_W-1:0]     start_per_s;

    uart_stim_fifo #(.DEPTH(DEPTH)) u_fifo (
        .core_clk  (core_clk),
        .rst_l     (rst_l),
        .push      (push_s),
        .push_data (push_data),
        .pop       (pop_s),
        .flush     (flush),
        .pop_data  (fifo_data_s),
        .level     (level),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Handshake, pop decision and clamped period for the next frame.
    always_comb begin
        push_ready  = ~fifo_full_s;
        push_s      = push_valid && push_ready;
        last_stop_s = (STOP_BITS == 1) ? 1'b1 : stop_idx_r;
        pop_s       = !fifo_empty_s && !flush &&
                      ((state_r == ST_IDLE) ||
                       ((state_r == ST_STOP) && (cnt_r == ZERO_CYC) && last_stop_s));
        if (bit_cycles < MIN_PER) begin
            start_per_s = MIN_PER;
        end else begin
            start_per_s = bit_cycles;
        end
    end

    // Frame FSM; a pop always starts a new frame, from IDLE or straight out of STOP.
    always_ff @(posedge core_clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r     <= ST_IDLE;
            data_r      <= 8'h00;
            per_r       <= MIN_PER;
            cnt_r       <= ZERO_CYC;
            bit_idx_r   <= 3'd0;
            stop_idx_r  <= 1'b0;
            par_en_r    <= 1'b0;
            par_odd_r   <= 1'b0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            byte_done_r <= 1'b0;
        end else begin
            byte_done_r <= 1'b0;
            if (pop_s) begin
                state_r   <= ST_START;
                data_r    <= fifo_data_s;
                per_r     <= start_per_s;
                cnt_r     <= start_per_s - ONE_CYC;
                par_en_r  <= parity_en;
                par_odd_r <= parity_odd;
                tx_r      <= 1'b0;
                busy_r    <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                    ST_START: begin
                        if (cnt_r == ZERO_CYC) begin
                            cnt_r     <= per_r - ONE_CYC;
                            tx_r      <= data_r[0];
                            bit_idx_r <= 3'd0;
                            state_r   <= ST_DATA;
                        end else begin
                            cnt_r <= cnt_r - ONE_CYC;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_r != ZERO_CYC) begin
                            cnt_r <= cnt_r - ONE_CYC;
                        end else if (bit_idx_r != LAST_BIT) begin
                            cnt_r     <= per_r - ONE_CYC;
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= data_r[bit_idx_r + 3'd1];
                        end else if (par_en_r) begin
                            cnt_r   <= per_r - ONE_CYC;
                            tx_r    <= calc_parity(data_r, par_odd_r);
                            state_r <= ST_PARITY;
                        end else begin
                            cnt_r      <= per_r - ONE_CYC;
                            tx_r       <= 1'b1;
                            stop_idx_r <= 1'b0;
                            state_r    <= ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        if (cnt_r == ZERO_CYC) begin
                            cnt_r      <= per_r - ONE_CYC;
                            tx_r       <= 1'b1;
                            stop_idx_r <= 1'b0;
                            state_r    <= ST_STOP;
                        end else begin
                            cnt_r <= cnt_r - ONE_CYC;
                        end
                    end
                    ST_STOP: begin
                        if (cnt_r != ZERO_CYC) begin
                            // Registered pulse lands on the final cycle of the last stop bit.
                            byte_done_r <= (cnt_r == ONE_CYC) && last_stop_s;
                            cnt_r       <= cnt_r - ONE_CYC;
                        end else if (!last_stop_s) begin
                            stop_idx_r <= 1'b1;
                            cnt_r      <= per_r - ONE_CYC;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_o      = tx_r;
    assign busy      = busy_r;
    assign byte_done = byte_done_r;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed self-checking bench for uart_stim_tx: frame shape, parity, back-to-back,
// FIFO full, period clamp, flush and asynchronous reset.
module tb_uart_stim_tx;

    logic        core_clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        push_valid = 1'b0;
    logic [7:0]  push_data = 8'h00;
    logic        flush = 1'b0;
    logic [15:0] bit_cycles = 16'd4;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        push_ready;
    logic        tx_o;
    logic        busy;
    logic [4:0]  level;
    logic        byte_done;

    int checks = 0;
    int errors = 0;
    int bd_total = 0;
    int max_level = 0;

    uart_stim_tx #(.DEPTH(16), .STOP_BITS(1), .CYC_W(16)) dut (
        .core_clk   (core_clk),
        .rst_l      (rst_l),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .flush      (flush),
        .bit_cycles (bit_cycles),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .tx_o       (tx_o),
        .busy       (busy),
        .level      (level),
        .byte_done  (byte_done)
    );

    always #5 core_clk = ~core_clk;

    always @(negedge core_clk) begin
        if (byte_done === 1'b1) bd_total++;
        if (int'(level) > max_level) max_level = int'(level);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] d, output int waited);
        waited = 0;
        while (push_ready !== 1'b1 && waited < 5000) begin
            @(negedge core_clk);
            waited++;
        end
        if (waited >= 5000) chk("push_timeout", push_ready, 1'b1);
        push_valid = 1'b1;
        push_data  = d;
        @(negedge core_clk);
        push_valid = 1'b0;
    endtask

    // Samples one frame cycle by cycle; sample k is taken after the k-th edge from the start edge.
    task automatic rx_frame(input int per, input bit pen, input bit started, input string tag,
                            output logic [7:0] data, output logic par, output int gap);
        logic smp [0:63];
        logic bd  [0:63];
        int len, hold_err, bd_cnt;
        len  = (10 + int'(pen)) * per;
        gap  = 0;
        data = 8'h00;
        par  = 1'b0;
        if (!started) begin
            do begin
                @(negedge core_clk);
                gap++;
            end while (tx_o !== 1'b0 && gap < 5000);
            if (tx_o !== 1'b0) begin
                chk({tag, "_start_timeout"}, tx_o, 1'b0);
                return;
            end
        end
        smp[0] = tx_o;
        bd[0]  = byte_done;
        for (int k = 1; k < len; k++) begin
            @(negedge core_clk);
            smp[k] = tx_o;
            bd[k]  = byte_done;
        end
        hold_err = 0;
        for (int b = 0; b < len / per; b++)
            for (int j = 1; j < per; j++)
                if (smp[b*per + j] !== smp[b*per]) hold_err++;
        bd_cnt = 0;
        for (int k = 0; k < len; k++)
            if (bd[k] === 1'b1) bd_cnt++;
        for (int i = 0; i < 8; i++) data[i] = smp[(1 + i) * per];
        if (pen) par = smp[9 * per];
        chk({tag, "_bit_hold"}, hold_err, 0);
        chk({tag, "_start_bit"}, smp[0], 1'b0);
        chk({tag, "_stop_bit"}, smp[(9 + int'(pen)) * per], 1'b1);
        chk({tag, "_byte_done_count"}, bd_cnt, 1);
        chk({tag, "_byte_done_last"}, bd[len-1], 1'b1);
    endtask

    int w, g, bd0, w_a, w17, low_cnt, mism;
    logic [7:0] d;
    logic p, p_b;
    logic [7:0] rxd [0:17];
    int gaps [0:17];

    initial begin
        repeat (3) @(negedge core_clk);
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_ready", push_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", level, 5'd0);
        chk("rst_byte_done", byte_done, 1'b0);
        rst_l = 1'b1;
        @(negedge core_clk);

        // 0x55, period 4, no parity: latency and exact frame shape
        push_byte(8'h55, w);
        chk("lat_level_one", level, 5'd1);
        chk("lat_tx_idle", tx_o, 1'b1);
        @(negedge core_clk);
        chk("lat_tx_start", tx_o, 1'b0);
        chk("lat_level_zero", level, 5'd0);
        chk("lat_busy", busy, 1'b1);
        bd0 = bd_total;
        rx_frame(4, 1'b0, 1'b1, "f55", d, p, g);
        chk("f55_data", d, 8'h55);
        @(negedge core_clk);
        chk("f55_busy_drop", busy, 1'b0);
        chk("f55_tx_idle", tx_o, 1'b1);
        chk("f55_bd_total", bd_total - bd0, 1);

        // Even parity; mid-frame control changes must not affect this frame
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push_byte(8'h03, w);
        @(negedge core_clk);
        chk("pe_started", tx_o, 1'b0);
        parity_odd = 1'b1;
        bit_cycles = 16'd9;
        rx_frame(4, 1'b1, 1'b1, "peven", d, p, g);
        chk("peven_data", d, 8'h03);
        chk("peven_bit", p, 1'b0);
        bit_cycles = 16'd4;
        push_byte(8'h03, w);
        rx_frame(4, 1'b1, 1'b0, "podd", d, p, g);
        chk("podd_data", d, 8'h03);
        chk("podd_bit", p, 1'b1);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        repeat (3) @(negedge core_clk);

        // Back-to-back frames
        bd0 = bd_total;
        fork
            begin
                push_byte(8'hA0, w_a);
                push_byte(8'h0F, w_a);
                push_byte(8'hFF, w_a);
            end
            begin
                for (int f = 0; f < 3; f++) rx_frame(4, 1'b0, 1'b0, "b2b", rxd[f], p_b, gaps[f]);
            end
        join
        chk("b2b_data0", rxd[0], 8'hA0);
        chk("b2b_data1", rxd[1], 8'h0F);
        chk("b2b_data2", rxd[2], 8'hFF);
        chk("b2b_gap1", gaps[1], 1);
        chk("b2b_gap2", gaps[2], 1);
        repeat (5) @(negedge core_clk);
        chk("b2b_bd_total", bd_total - bd0, 3);
        chk("b2b_busy_end", busy, 1'b0);

        // Fill to full while a frame is active; 17th push waits for the first pop
        max_level = 0;
        fork
            begin
                push_byte(8'h11, w_a);
                repeat (2) @(negedge core_clk);
                for (int i = 1; i <= 16; i++) push_byte(8'(8'h20 + i), w_a);
                chk("full_level", level, 5'd16);
                chk("full_ready_low", push_ready, 1'b0);
                push_byte(8'h31, w17);
                chk("full_held_off", (w17 > 0), 1'b1);
            end
            begin
                for (int f = 0; f < 18; f++) rx_frame(4, 1'b0, 1'b0, "full", rxd[f], p_b, gaps[f]);
            end
        join
        mism = 0;
        if (rxd[0] !== 8'h11) mism++;
        for (int i = 1; i <= 16; i++) if (rxd[i] !== 8'(8'h20 + i)) mism++;
        if (rxd[17] !== 8'h31) mism++;
        chk("full_order", mism, 0);
        mism = 0;
        for (int i = 1; i < 18; i++) if (gaps[i] != 1) mism++;
        chk("full_contiguous", mism, 0);
        chk("full_max_level", max_level, 16);

        // Period clamp for bit_cycles 0 and 1
        bit_cycles = 16'd0;
        push_byte(8'h55, w);
        rx_frame(2, 1'b0, 1'b0, "clamp0", d, p, g);
        chk("clamp0_data", d, 8'h55);
        bit_cycles = 16'd1;
        push_byte(8'hAA, w);
        rx_frame(2, 1'b0, 1'b0, "clamp1", d, p, g);
        chk("clamp1_data", d, 8'hAA);
        bit_cycles = 16'd4;
        repeat (3) @(negedge core_clk);

        // Flush mid-frame with 5 queued; same-cycle push is dropped
        bd0 = bd_total;
        fork
            begin
                push_byte(8'h11, w_a);
                for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i), w_a);
                chk("flush_pre_level", level, 5'd5);
                repeat (10) @(negedge core_clk);
                flush      = 1'b1;
                push_valid = 1'b1;
                push_data  = 8'hEE;
                @(negedge core_clk);
                flush      = 1'b0;
                push_valid = 1'b0;
                chk("flush_level", level, 5'd0);
                chk("flush_busy_kept", busy, 1'b1);
            end
            begin
                rx_frame(4, 1'b0, 1'b0, "flush", rxd[0], p_b, gaps[0]);
            end
        join
        chk("flush_cur_data", rxd[0], 8'h11);
        low_cnt = 0;
        repeat (200) begin
            @(negedge core_clk);
            if (tx_o !== 1'b1) low_cnt++;
        end
        chk("flush_no_more_frames", low_cnt, 0);
        chk("flush_busy_end", busy, 1'b0);
        chk("flush_level_end", level, 5'd0);
        chk("flush_bd_total", bd_total - bd0, 1);

        // Asynchronous reset mid-DATA
        push_byte(8'h00, w);
        push_byte(8'h12, w);
        repeat (10) @(negedge core_clk);
        chk("arst_pre_tx", tx_o, 1'b0);
        chk("arst_pre_level", level, 5'd1);
        #2;
        rst_l = 1'b0;
        #1;
        chk("arst_tx", tx_o, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_level", level, 5'd0);
        @(negedge core_clk);
        rst_l = 1'b1;
        @(negedge core_clk);
        push_byte(8'h3C, w);
        rx_frame(4, 1'b0, 1'b0, "post_rst", d, p, g);
        chk("post_rst_data", d, 8'h3C);
        chk("post_rst_latency", g, 1);
        @(negedge core_clk);
        chk("post_rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
